// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader_if
//  Purpose  : Bundles the loader's byte-stream handshake, instruction-memory
//             write port and CPU control/status lines.
//  Ports    : in_data/in_valid/in_ready  byte stream (valid/ready)
//             reload                     re-arm pulse
//             im_we/im_addr/im_wdata     instruction-memory write port
//             cpu_rst/done/err           CPU reset and load status
//  Modports : slave  - the loader itself
//             master - the byte source / system side
//  Revision : 1.0  initial release
// ============================================================================
interface program_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  modport slave (
    input  in_data, in_valid, reload,
    output in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );

  modport master (
    output in_data, in_valid, reload,
    input  in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Boot-time instruction-memory writer. Receives a byte stream
//             (count, word bytes low-first, XOR checksum), writes 16-bit words
//             to consecutive even addresses and holds the CPU in reset until
//             the image is loaded and the checksum verified.
//  Ports    : clk  - single clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - program_loader_if.slave (stream, IM write port, status)
//  Revision : 1.0  initial release
// ============================================================================
module program_loader (
  input  wire logic       clk,
  input  wire logic       rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN = 3'd0,
    S_LO  = 3'd1,
    S_HI  = 3'd2,
    S_CHK = 3'd3,
    S_RUN = 3'd4,
    S_ERR = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  remaining;   // words still to receive; 128 encoded as 8'd128
  logic [6:0]  index;       // word index, im_addr = {index, 0}
  logic [7:0]  chk_acc;     // running XOR of N and all word bytes
  logic [7:0]  lo_byte;
  logic        xfer;

  // in_ready is a register, so the handshake is glitch-free
  assign xfer = bus.in_valid & bus.in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN:   if (xfer) state_nxt = S_LO;
      S_LO:    if (xfer) state_nxt = S_HI;
      S_HI:    if (xfer) state_nxt = (remaining == 8'd1) ? S_CHK : S_LO;
      S_CHK:   if (xfer) state_nxt = (bus.in_data == chk_acc) ? S_RUN : S_ERR;
      S_RUN,
      S_ERR:   if (bus.reload) state_nxt = S_LEN;
      default: state_nxt = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LEN;
      bus.in_ready <= 1'b1;
      bus.cpu_rst  <= 1'b1;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= 8'h00;
      bus.im_wdata <= 16'h0000;
      remaining    <= 8'd0;
      index        <= 7'd0;
      chk_acc      <= 8'd0;
      lo_byte      <= 8'd0;
    end else begin
      state <= state_nxt;
      // Status outputs are registered decodes of the next state so they
      // change on the same edge as the state itself.
      bus.in_ready <= (state_nxt == S_LEN) || (state_nxt == S_LO) ||
                      (state_nxt == S_HI)  || (state_nxt == S_CHK);
      bus.cpu_rst  <= (state_nxt != S_RUN);
      bus.done     <= (state_nxt == S_RUN);
      bus.err      <= (state_nxt == S_ERR);
      bus.im_we    <= 1'b0;

      if (xfer) begin
        case (state)
          S_LEN: begin
            remaining <= (bus.in_data == 8'd0) ? 8'd128 : bus.in_data;
            chk_acc   <= bus.in_data;
            index     <= 7'd0;
          end
          S_LO: begin
            lo_byte <= bus.in_data;
            chk_acc <= chk_acc ^ bus.in_data;
          end
          S_HI: begin
            chk_acc      <= chk_acc ^ bus.in_data;
            bus.im_we    <= 1'b1;
            bus.im_addr  <= {index, 1'b0};
            bus.im_wdata <= {bus.in_data, lo_byte};
            // index wraps to 0 only after word 127, when no write follows
            index        <= index + 7'd1;
            remaining    <= remaining - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader. Stimulus pushes the
//             expected memory writes into a queue; a monitor pops and compares
//             each im_we pulse. Status outputs are checked after each load.
//  Revision : 1.0  initial release
// ============================================================================
module tb_program_loader;

  logic clk = 1'b0;
  logic rst;

  program_loader_if bus ();

  program_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] img[128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write: actual addr=%02h data=%04h, expected no write",
                 bus.im_addr, bus.im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.im_addr !== e.addr || bus.im_wdata !== e.data) begin
          errors++;
          $display("FAIL write: actual addr=%02h data=%04h, expected addr=%02h data=%04h",
                   bus.im_addr, bus.im_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Present one byte after `gap` idle cycles and wait for it to be taken.
  // Inputs change #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: in_ready stayed %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Reference model: stream = N, words low-first, XOR of all preceding bytes.
  task automatic run_load(input string name, input int nwords, input bit corrupt,
                          input int gap_min, input int gap_max);
    logic [7:0] bytes[$];
    logic [7:0] cks;
    wr_t        w;
    bytes.push_back((nwords == 128) ? 8'd0 : 8'(nwords));
    for (int i = 0; i < nwords; i++) begin
      bytes.push_back(img[i][7:0]);
      bytes.push_back(img[i][15:8]);
      w.addr = 8'(2 * i);
      w.data = img[i];
      exp_q.push_back(w);
    end
    cks = 8'd0;
    foreach (bytes[k]) cks = cks ^ bytes[k];
    if (corrupt) cks = cks ^ 8'h01;
    bytes.push_back(cks);
    foreach (bytes[k]) send_byte(bytes[k], $urandom_range(gap_max, gap_min));
    @(negedge clk);
    check({name, "_done"},     {31'd0, bus.done},     {31'd0, !corrupt});
    check({name, "_err"},      {31'd0, bus.err},      {31'd0, corrupt});
    check({name, "_cpu_rst"},  {31'd0, bus.cpu_rst},  {31'd0, corrupt});
    check({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({name, "_pending"},  exp_q.size(),          32'd0);
  endtask

  task automatic pulse_reload(input string name);
    @(posedge clk);
    #1;
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
    @(negedge clk);
    check({name, "_cpu_rst"},  {31'd0, bus.cpu_rst},  32'd1);
    check({name, "_done"},     {31'd0, bus.done},     32'd0);
    check({name, "_err"},      {31'd0, bus.err},      32'd0);
    check({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic set_basic();
    img[0] = 16'h0510;
    img[1] = 16'h0720;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    rst          = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_im_we",    {31'd0, bus.im_we},    32'd0);
    check("rst_im_addr",  {24'd0, bus.im_addr},  32'h00);
    check("rst_im_wdata", {16'd0, bus.im_wdata}, 32'h0000);
    check("rst_cpu_rst",  {31'd0, bus.cpu_rst},  32'd1);
    check("rst_done",     {31'd0, bus.done},     32'd0);
    check("rst_err",      {31'd0, bus.err},      32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Basic, then bad checksum
    set_basic();
    run_load("basic", 2, 1'b0, 0, 0);
    pulse_reload("reload_run");
    run_load("badcks", 2, 1'b1, 0, 0);
    pulse_reload("reload_err");

    // Full 128-word image
    for (int i = 0; i < 128; i++) img[i] = 16'($urandom);
    run_load("full", 128, 1'b0, 0, 0);
    pulse_reload("reload_full");

    // Gapped basic stream
    set_basic();
    run_load("gapped", 2, 1'b0, 3, 3);
    pulse_reload("reload_gap");

    // Reset mid-load: only the first word is written
    w.addr = 8'h00;
    w.data = 16'h0510;
    exp_q.push_back(w);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    send_byte(8'h05, 0);
    send_byte(8'h20, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_cpu_rst",  {31'd0, bus.cpu_rst},  32'd1);
    check("midrst_done",     {31'd0, bus.done},     32'd0);
    check("midrst_pending",  exp_q.size(),          32'd0);
    set_basic();
    run_load("after_rst", 2, 1'b0, 0, 0);

    // Reload from RUN and a one-word image
    pulse_reload("reload_one");
    img[0] = 16'h55AA;
    run_load("one_word", 1, 1'b0, 0, 0);
    pulse_reload("reload_rand");

    // Random images, random gaps, occasional corrupted checksum
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) img[i] = 16'($urandom);
      run_load("random", n, ($urandom_range(3, 0) == 0), 0, 2);
      pulse_reload("reload_loop");
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory of the 8-bit pipelined CPU. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive even addresses. The CPU reads those addresses with PC steps of +2. The block holds the CPU in reset until the whole image has been written and its checksum has been verified, then releases it. It sits beside the CPU top level: it drives the instruction-memory write port and the CPU's `rst`.

## Interface
- No parameters. Data width is 8 bits, word width is 16 bits and address width is 8 bits, all fixed to match the CPU.
- `clk`  in  1  single clock for the block. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte. A transfer occurs on a rising edge where `in_valid & in_ready`.
- `reload`  in  1  single-cycle pulse. Re-arms the loader from RUN or ERR.
- `im_we`  out  1  instruction-memory write strobe, one cycle per word.
- `im_addr`  out  8  write address: 2 × word index, always even.
- `im_wdata`  out  16  write word. [7:0] = opcode/register field, [15:8] = immediate.
- `cpu_rst`  out  1  reset to the CPU. High while loading or in error.
- `done`  out  1  image loaded and verified; CPU running.
- `err`  out  1  checksum mismatch; CPU held in reset.

## Operation
- Stream format:
  - byte 0 = N, the word count. N = 0 means 128 words.
  - next 2N bytes = words, low byte first, then high byte.
  - final byte = checksum, equal to the XOR of N and all 2N word bytes.
- States: LEN, LO, HI, CHK, RUN, ERR. `rst` enters LEN.
- LEN:
  - `in_ready` = 1.
  - On transfer: latch N into the remaining-word count, set the running XOR to N, clear the word index, go to LO.
- LO:
  - `in_ready` = 1.
  - On transfer: latch the low byte, XOR it into the running checksum, go to HI.
- HI:
  - `in_ready` = 1.
  - On transfer: XOR the byte into the running checksum, register `im_wdata` = {byte, low}, `im_addr` = index × 2, and `im_we` = 1 for the next cycle.
  - Increment the index and decrement the remaining count.
  - Go to LO if words remain; go to CHK if this was the last word.
- CHK:
  - `in_ready` = 1.
  - On transfer: if the byte equals the running XOR, go to RUN. Otherwise go to ERR.
- RUN: `in_ready` = 0, `cpu_rst` = 0, `done` = 1.
- ERR: `in_ready` = 0, `cpu_rst` = 1, `err` = 1.
- `reload` in RUN or ERR:
  - Go to LEN; `cpu_rst` = 1, and `done`/`err` clear on the same edge.
  - `reload` is ignored in LEN, LO, HI and CHK.
- Address arithmetic:
  - The index is 7 bits and `im_addr` = {index, 1'b0}.
  - Word 127 is written to 0xFE. A 128-word load never wraps.
- Addresses beyond the last loaded word are not touched; the instruction memory keeps its old contents there.
- Bytes presented while `in_ready` = 0 are not consumed. The source must hold them.

## Timing
- All outputs are registered.
- Values during and immediately after the `rst` cycle:
  - `im_we` = 0, `im_addr` = 0x00, `im_wdata` = 0x0000
  - `cpu_rst` = 1, `done` = 0, `err` = 0
  - `in_ready` = 1 (state LEN)
- Throughput: one byte per cycle when `in_valid` is held high. There are no internal stall cycles.
- Write latency: `im_we` is high in the cycle immediately after the HI-byte transfer edge, for exactly one cycle. `im_addr` and `im_wdata` hold their values until the next write.
- Release: `cpu_rst` falls and `done` rises on the edge after the checksum transfer. At that point the last `im_we` has already completed, so the CPU's first fetch sees the full image.
- `rst` asserted mid-load:
  - Abandons the partial image and returns to LEN.
  - Words already written stay in memory.
  - `cpu_rst` stays high throughout.
- `in_valid` may drop between any two bytes; state is held indefinitely.

## Test plan
- Basic load: send 0x02, 0x10, 0x05, 0x20, 0x07, 0x30.
  - Required writes: `im_we` pulses for addr 0x00 with data 0x0510, then addr 0x02 with data 0x0720.
  - Then `cpu_rst` 0→ and `done` = 1 one cycle after the 0x30 transfer.
  - `in_ready` = 0 in RUN.
- Bad checksum: same stream with final byte 0x31.
  - Both writes occur.
  - End state: `err` = 1, `cpu_rst` = 1, `done` = 0.
  - A `reload` pulse returns to LEN with `err` = 0.
- Full image: N = 0x00 followed by 256 bytes.
  - Required: 128 writes with `im_addr` 0x00, 0x02, …, 0xFE.
  - Checksum: the XOR of all 257 bytes must be accepted.
- Gapped stream: basic stream with `in_valid` low for 3 random cycles between each byte.
  - Required: identical writes and final state.
  - No extra `im_we` pulses.
- Reset mid-load: assert `rst` after 0x02, 0x10, 0x05, 0x20.
  - Required: exactly one write (0x00 / 0x0510), then LEN with `cpu_rst` = 1.
  - A subsequent full basic stream loads correctly.
- Reload from RUN: after the basic load, pulse `reload` and send 0x01, 0xAA, 0x55, 0xFE.
  - Required: `cpu_rst` high from the `reload` edge, one write (0x00 / 0x55AA), then `done` = 1.
